router_output_arbiter: RTL
==========================

Name: router_output_arbiter

Overview:
- Wormhole output-port arbiter for the NoC router.
- Shares one 68-bit output channel among NUM_IN input-port requesters using round-robin arbitration.
- Holds the grant for a whole packet, from head flit to tail flit.
- Tracks downstream buffer credits from the flow-control return bits and stalls when credits run out.
- Sits between the input buffers and one router output slice.

Parameters:
- NUM_IN, 4, number of requesting input ports (2..8).
- CREDITS_MAX, 4, downstream buffer depth in flits; also the credit counter's reset value.
- CW, 3, credit counter width; must satisfy 2^CW > CREDITS_MAX.

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- REQ_VALID  input  NUM_IN  bit i: input port i presents a flit.
- REQ_FLITS  input  NUM_IN*68  flit of port i at bits [68*i : 68*i+67]. Flit bit 0 = valid, bit 1 = head, bit 2 = tail, bits 3..67 = payload.
- FLOW_CTRL_IN_OP  input  2  bit 0: one credit returned by downstream this cycle; bit 1: reserved, ignored.
- GRANT_POP  output  NUM_IN  one-hot pulse; port i's flit was consumed this cycle (combinational).
- CHANNEL_OUT_OP  output  68  registered outgoing flit; all-zero when idle.
- ERROR  output  1  sticky error flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - CHANNEL_OUT_OP=0, ERROR=0, GRANT_POP=0.
  - state=IDLE, owner=0, rr_ptr=0, credits=CREDITS_MAX.
- A flit is "eligible" when REQ_VALID[i]=1 and its flit bit 0=1.
- IDLE state:
  - Candidates are eligible ports whose flit has head=1.
  - Winner is the first candidate searching i = rr_ptr, rr_ptr+1, ... modulo NUM_IN.
  - Send only if credits>0. On send: GRANT_POP[winner]=1, flit is registered to CHANNEL_OUT_OP next cycle, credits is decremented.
  - If the flit has tail=0: go to LOCKED, owner=winner.
  - If head and tail are both 1 (single-flit packet): stay IDLE, rr_ptr=winner+1 mod NUM_IN.
- LOCKED state:
  - Only the owner is serviced; every other port sees GRANT_POP=0.
  - Owner eligible and credits>0: send as in IDLE.
  - Owner flit has tail=1: go to IDLE, rr_ptr=owner+1 mod NUM_IN.
  - Owner flit has head=1 while LOCKED: set ERROR. The flit is still forwarded, and the lock continues.
- Non-head flits in IDLE: never granted and never popped; they wait.
- Latency: one cycle from GRANT_POP to the flit appearing on CHANNEL_OUT_OP.
- Cycles with no send: CHANNEL_OUT_OP=0 the next cycle (bubble).
- Credits, per cycle:
  - credits_next = credits - send + FLOW_CTRL_IN_OP[0].
  - Send and credit return in the same cycle leave credits unchanged.
  - A send is allowed at credits=0 only if a credit return arrives in the same cycle? No. Sends require credits>0 as registered; a same-cycle return does not enable a send.
  - A return that would make credits > CREDITS_MAX: set ERROR and saturate credits at CREDITS_MAX.
- ERROR is sticky; only reset clears it.
- Reset asserted mid-packet: the lock is dropped and credits are reloaded. Upstream and downstream are reset together.

Test Plan:
- Single port, 3-flit packet, CREDITS_MAX=4:
  - Port 2 presents H, B, T back-to-back.
  - GRANT_POP=0100 for 3 cycles; CHANNEL_OUT_OP carries H, B, T one cycle later; credits ends at 1; rr_ptr ends at 3.
- Round-robin fairness:
  - Ports 0 and 3 both continuously offer single-flit packets (head=tail=1).
  - Grants alternate 0, 3, 0, 3 starting from rr_ptr=0.
  - A credit is returned every cycle, so there is no stall.
- Wormhole lock:
  - Port 1 starts a 4-flit packet; port 0 presents a head flit meanwhile.
  - Port 0 gets no grant until the cycle after port 1's tail is sent; port 0 is granted next.
- Credit stall:
  - No credit returns; one port sends 6 flits of one packet.
  - The first 4 are granted, then GRANT_POP=0 and the output is zero.
  - After a single FLOW_CTRL_IN_OP[0] pulse, exactly one more flit is sent.
- Credit overflow:
  - Return a credit at credits=CREDITS_MAX.
  - ERROR=1 next cycle and stays 1; credits stays 4.
  - Asserting reset clears ERROR to 0.
- Async reset mid-packet:
  - Drop reset low between two clock edges during LOCKED.
  - CHANNEL_OUT_OP=0 immediately.
  - After release, a new head from a different port is granted; credits=CREDITS_MAX.

Source files
------------

// File: rtl/router_output_arbiter_if.sv
// Request/response bundle between the input buffers, the output arbiter and
// the downstream flow-control return path of one router output slice.
interface router_output_arbiter_if #(
  parameter int NUM_IN = 4
);
  logic [NUM_IN-1:0]    REQ_VALID;
  logic [NUM_IN*68-1:0] REQ_FLITS;
  logic [1:0]           FLOW_CTRL_IN_OP;
  logic [NUM_IN-1:0]    GRANT_POP;
  logic [67:0]          CHANNEL_OUT_OP;
  logic                 ERROR;

  modport master (
    output REQ_VALID,
    output REQ_FLITS,
    output FLOW_CTRL_IN_OP,
    input  GRANT_POP,
    input  CHANNEL_OUT_OP,
    input  ERROR
  );

  modport slave (
    input  REQ_VALID,
    input  REQ_FLITS,
    input  FLOW_CTRL_IN_OP,
    output GRANT_POP,
    output CHANNEL_OUT_OP,
    output ERROR
  );
endinterface

// File: rtl/router_output_arbiter.sv
// Wormhole output-port arbiter: round-robin over head flits, packet-long lock,
// credit-based stall against the downstream buffer, sticky protocol error flag.
module router_output_arbiter #(
  parameter int NUM_IN      = 4,
  parameter int CREDITS_MAX = 4,
  parameter int CW          = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  router_output_arbiter_if.slave bus
);
  localparam int FW = 68;
  localparam int PW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_next_s;
  logic [PW-1:0]       owner_r;
  logic [PW-1:0]       owner_next_s;
  logic [PW-1:0]       rr_ptr_r;
  logic [PW-1:0]       rr_next_s;
  logic [CW-1:0]       credits_r;
  logic [CW-1:0]       credits_next_s;
  logic [CW:0]         credit_sum_s;
  logic [FW-1:0]       out_r;
  logic                error_r;

  logic [FW-1:0]       flit_s [NUM_IN];
  logic [NUM_IN-1:0]   eligible_s;
  logic [NUM_IN-1:0]   head_s;
  logic [NUM_IN-1:0]   tail_s;
  logic [PW:0]         pick_s;
  logic                send_s;
  logic [PW-1:0]       sel_s;
  logic [FW-1:0]       send_flit_s;
  logic [NUM_IN-1:0]   grant_s;
  logic                ret_s;
  logic                lock_err_s;
  logic                ovf_s;
  logic                unused_flow_s;

  // First set bit of cand at or after ptr (wrapping); MSB of result = found.
  function automatic logic [PW:0] rr_pick(input logic [NUM_IN-1:0] cand,
                                          input logic [PW-1:0]     ptr);
    logic [PW:0] res;
    logic        found;
    int          idx;
    res   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_IN) begin
        idx = idx - NUM_IN;
      end else begin
        idx = idx;
      end
      if (!found && cand[idx]) begin
        found = 1'b1;
        res   = {1'b1, PW'(idx)};
      end else begin
        found = found;
      end
    end
    return res;
  endfunction

  function automatic logic [PW-1:0] next_port(input logic [PW-1:0] p);
    if (int'(p) == NUM_IN - 1) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  assign ret_s         = bus.FLOW_CTRL_IN_OP[0];
  assign unused_flow_s = bus.FLOW_CTRL_IN_OP[1];

  // Split the flat flit bus and decode valid/head/tail per port.
  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      flit_s[i]     = bus.REQ_FLITS[i*FW +: FW];
      eligible_s[i] = bus.REQ_VALID[i] & flit_s[i][0];
      head_s[i]     = flit_s[i][1];
      tail_s[i]     = flit_s[i][2];
    end
  end

  // State register: FSM state, packet owner and round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      owner_r  <= '0;
      rr_ptr_r <= '0;
    end else begin
      state_r  <= state_next_s;
      owner_r  <= owner_next_s;
      rr_ptr_r <= rr_next_s;
    end
  end

  // Output decode: which port (if any) is popped this cycle.
  always_comb begin
    send_s  = 1'b0;
    sel_s   = '0;
    grant_s = '0;
    pick_s  = rr_pick(eligible_s & head_s, rr_ptr_r);
    // Sends are gated by the registered credit count only.
    if (reset && (credits_r != '0)) begin
      case (state_r)
        IDLE: begin
          if (pick_s[PW]) begin
            send_s = 1'b1;
            sel_s  = pick_s[PW-1:0];
          end else begin
            send_s = 1'b0;
          end
        end
        LOCKED: begin
          if (eligible_s[owner_r]) begin
            send_s = 1'b1;
            sel_s  = owner_r;
          end else begin
            send_s = 1'b0;
          end
        end
        default: begin
          send_s = 1'b0;
        end
      endcase
    end else begin
      send_s = 1'b0;
    end
    send_flit_s = flit_s[sel_s];
    if (send_s) begin
      grant_s[sel_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  // Next-state logic: lock on a multi-flit head, release on the tail.
  always_comb begin
    state_next_s = state_r;
    owner_next_s = owner_r;
    rr_next_s    = rr_ptr_r;
    lock_err_s   = 1'b0;
    if (send_s) begin
      case (state_r)
        IDLE: begin
          if (tail_s[sel_s]) begin
            rr_next_s = next_port(sel_s);
          end else begin
            state_next_s = LOCKED;
            owner_next_s = sel_s;
          end
        end
        LOCKED: begin
          // A fresh head inside a packet is a protocol error but still forwarded.
          if (head_s[owner_r]) begin
            lock_err_s = 1'b1;
          end else begin
            lock_err_s = 1'b0;
          end
          if (tail_s[owner_r]) begin
            state_next_s = IDLE;
            rr_next_s    = next_port(owner_r);
          end else begin
            state_next_s = LOCKED;
          end
        end
        default: begin
          state_next_s = IDLE;
        end
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // Credit bookkeeping with saturation on an over-return.
  always_comb begin
    credit_sum_s = {1'b0, credits_r} + {{CW{1'b0}}, ret_s} - {{CW{1'b0}}, send_s};
    if (credit_sum_s > (CW+1)'(CREDITS_MAX)) begin
      credits_next_s = CW'(CREDITS_MAX);
      ovf_s          = 1'b1;
    end else begin
      credits_next_s = credit_sum_s[CW-1:0];
      ovf_s          = 1'b0;
    end
  end

  // Credit counter and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credits_r <= CW'(CREDITS_MAX);
      error_r   <= 1'b0;
    end else begin
      credits_r <= credits_next_s;
      error_r   <= error_r | lock_err_s | ovf_s;
    end
  end

  // Registered output channel; a cycle without a send leaves a zero bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_r <= '0;
    end else if (send_s) begin
      out_r <= send_flit_s;
    end else begin
      out_r <= '0;
    end
  end

  assign bus.GRANT_POP      = grant_s;
  assign bus.CHANNEL_OUT_OP = out_r;
  assign bus.ERROR          = error_r;
endmodule
